// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: opcodes, instruction field
// positions, fetch FSM encoding and the default reset PC.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int TGT_MSB = 25;
  localparam int TGT_LSB = 0;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection: sequential, BEQ target or J target.
// Jump has priority over a taken branch; every target is word aligned.
module mips_next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic        unused_opc;

  // Opcode is decoded by the control path, not needed for target math.
  assign unused_opc = ^instr[OPC_MSB:OPC_LSB];

  assign pc_plus4 = pc + 32'd4;
  assign br_off   = {{14{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB], 2'b00};
  assign br_tgt   = pc_plus4 + br_off;
  assign j_tgt    = {pc_plus4[31:28], instr[TGT_MSB:TGT_LSB], 2'b00};

  // Priority select of the next fetch address.
  always_comb begin
    next_pc = pc_plus4;
    if (jump)                next_pc = j_tgt;
    else if (branch && zero) next_pc = br_tgt;
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: holds the PC, requests words from instruction
// memory and presents the registered instruction to decode over valid/ready.
// Optional macro IFETCH_PERF_CNT_EN adds instr_count and redirect_count.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]       instr_count,
  output logic [15:0]       redirect_count
`endif
);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic              accept;

  // pc only moves on the accepting edge, so it is also the held instr's PC.
  assign imem_addr = pc;
  assign pc_out    = pc;
  assign opcode    = instr[OPC_MSB:OPC_LSB];
  assign funct     = instr[FN_MSB:FN_LSB];
  assign accept    = (state == S_HOLD) && instr_ready;

  mips_next_pc u_next_pc (
    .pc       (pc),
    .instr    (instr),
    .branch   (branch),
    .zero     (zero),
    .jump     (jump),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ready) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // PC and instruction registers; a response arriving outside S_REQ is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      if ((state == S_REQ) && imem_ready) instr <= imem_rdata;
      if (accept)                         pc    <= next_pc;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic redirect;
  assign redirect = jump || (branch && zero);

  // Handshake counter wraps; redirect counter saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_count    <= '0;
      redirect_count <= '0;
    end else if (accept) begin
      instr_count <= instr_count + 32'd1;
      if (redirect && (redirect_count != 16'hFFFF))
        redirect_count <= redirect_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed cases then random
// fetches compared against a PC-level reference model.
module tb_mips_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        branch;
  logic        zero;
  logic        jump;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] instr_count;
  logic [15:0] redirect_count;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mpc;
  logic [31:0] mcount;
  logic [15:0] mredir;

  always #5 clk = ~clk;

  mips_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .opcode      (opcode),
    .funct       (funct),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .instr_count    (instr_count),
    .redirect_count (redirect_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_counters();
`ifdef IFETCH_PERF_CNT_EN
    chk("instr_count", instr_count, mcount);
    chk("redirect_count", 32'(redirect_count), 32'(mredir));
`endif
  endtask

  // Reference: where the next fetch goes, from the ISA rules directly.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] rd,
                                             input logic b, input logic z, input logic j);
    logic [31:0] p4;
    int          off;
    p4 = pc + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ((rd & 32'h03FF_FFFF) << 2);
    if (b && z) begin
      off = int'(rd & 32'h0000_FFFF);
      if (off > 32767) off = off - 65536;
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  // One full fetch: starts and ends at a negedge with the DUT in S_REQ.
  task automatic fetch(input logic [31:0] rd, input int dly, input int bp,
                       input logic b, input logic z, input logic j);
    logic [31:0] npc;
    chk("req_on", 32'(imem_req), 32'd1);
    chk("addr", imem_addr, mpc);
    chk("valid_lo", 32'(instr_valid), 32'd0);
    repeat (dly) begin
      @(posedge clk); @(negedge clk);
      chk("addr_stable", imem_addr, mpc);
      chk("req_hold", 32'(imem_req), 32'd1);
    end
    imem_ready = 1'b1;
    imem_rdata = rd;
    @(posedge clk); @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    chk("valid_hi", 32'(instr_valid), 32'd1);
    chk("req_off", 32'(imem_req), 32'd0);
    chk("instr", instr, rd);
    chk("opcode", 32'(opcode), rd >> 26);
    chk("funct", 32'(funct), rd & 32'h3F);
    chk("pc_out", pc_out, mpc);
    chk("pc_plus4", pc_plus4, mpc + 32'd4);
    repeat (bp) begin
      instr_ready = 1'b0;
      branch = $urandom; zero = $urandom; jump = $urandom;
      @(posedge clk); @(negedge clk);
      chk("bp_valid", 32'(instr_valid), 32'd1);
      chk("bp_instr", instr, rd);
      chk("bp_pc", pc_out, mpc);
      chk("bp_req", 32'(imem_req), 32'd0);
    end
    instr_ready = 1'b1;
    branch = b; zero = z; jump = j;
    npc = model_next(mpc, rd, b, z, j);
    @(posedge clk); @(negedge clk);
    instr_ready = 1'b0;
    branch = $urandom; zero = $urandom; jump = $urandom;
    mpc = npc;
    mcount = mcount + 32'd1;
    if ((j || (b && z)) && mredir != 16'hFFFF) mredir = mredir + 16'd1;
    chk_counters();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    branch = 1'b0; zero = 1'b0; jump = 1'b0;
    mpc = 32'h0; mcount = '0; mredir = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_funct", 32'(funct), 32'h0);
    chk_counters();
    rst = 1'b0;
    chk("idle_req", 32'(imem_req), 32'd0);
    @(posedge clk); @(negedge clk);

    // Sequential fetch, then backpressure.
    fetch(32'h012A_4020, 0, 0, 1'b0, 1'b0, 1'b0);
    fetch(32'h8C08_0004, 1, 3, 1'b0, 1'b0, 1'b0);
    fetch(32'hAC08_0008, 0, 0, 1'b0, 1'b0, 1'b0);
    fetch(32'h0000_0000, 2, 1, 1'b0, 1'b0, 1'b0);
    // BEQ at 0x10 taken (back to 0x10), then not taken.
    chk("pc_at_beq", mpc, 32'h10);
    fetch(32'h1000_FFFF, 0, 0, 1'b1, 1'b1, 1'b0);
    chk("beq_taken_model", mpc, 32'h10);
    fetch(32'h1000_FFFF, 0, 0, 1'b1, 1'b0, 1'b0);
    fetch(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0);
    fetch(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0);
    fetch(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0);
    // Jump beats a taken branch.
    fetch(32'h0800_0040, 0, 0, 1'b1, 1'b1, 1'b1);
    chk("jump_model", mpc, 32'h100);
    // Branch backwards to 0xFFFFFFFC, then wrap to 0.
    fetch(32'h1000_FFBE, 0, 0, 1'b1, 1'b1, 1'b0);
    chk("wrap_pc_model", mpc, 32'hFFFF_FFFC);
    fetch(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0);
    fetch(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0);

    // Reset in S_REQ; memory answers next cycle and must be ignored.
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    mpc = 32'h0; mcount = '0; mredir = '0;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk_counters();
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); @(negedge clk);
    imem_ready = 1'b0;
    chk("post_rst_valid", 32'(instr_valid), 32'd0);
    chk("post_rst_instr", instr, 32'h0);
    fetch(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0);

    // Random fetches against the model.
    for (int i = 0; i < 40; i++) begin
      fetch($urandom, $urandom_range(0, 2), $urandom_range(0, 2),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    chk("final_addr", imem_addr, mpc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
